// File: rtl/sort_pkg.sv
// Shared types and helpers for the sorted insertion buffer (sort_array / sort_cell).
package sort_pkg;

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} sort_state_t;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sort_cell.sv
// One slot of the insertion-sort array: stores a value and a valid bit, and
// shifts toward the tail on insert or toward the head on pop.
module sort_cell
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_new,
    input  logic [DATA_WIDTH-1:0] i_up_data,
    input  logic                  i_up_valid,
    input  logic                  i_up_flag,
    input  logic [DATA_WIDTH-1:0] i_dn_data,
    input  logic                  i_dn_valid,
    input  logic                  i_shift_in,
    input  logic                  i_shift_out,
    input  logic                  i_cmp,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_flag
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    // The flag is monotonic along the array, so the first set flag marks the insert slot.
    assign o_flag  = i_cmp || !r_valid;
    assign o_data  = r_data;
    assign o_valid = r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_shift_in) begin
            if (i_up_flag) begin
                r_data  <= i_up_data;
                r_valid <= i_up_valid;
            end else if (o_flag) begin
                r_data  <= i_new;
                r_valid <= 1'b1;
            end
        end else if (i_shift_out) begin
            r_data  <= i_dn_data;
            r_valid <= i_dn_valid;
        end
    end

endmodule

// File: rtl/sort_array.sv
// DEPTH-entry insertion-sort buffer with valid/ready on both sides.
// Define SORT_ARRAY_DESCEND_EN to keep the largest value at slot 0.
module sort_array
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic [DATA_WIDTH-1:0]              in_data,
    output logic                               in_ready,
    input  logic                               drain,
    output logic                               out_valid,
    output logic [DATA_WIDTH-1:0]              out_data,
    input  logic                               out_ready,
    output logic [count_width(DEPTH)-1:0]      count,
    output logic                               full,
    output logic                               dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // ready/valid outputs depend only on registered state.

    localparam int              CW       = count_width(DEPTH);
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]   ONE_CNT  = CW'(1);
    localparam logic            ST_FILL  = 1'b0;
    localparam logic            ST_DRAIN = 1'b1;

    logic          r_state;
    logic [CW-1:0] r_count;

    logic [DATA_WIDTH-1:0] w_data  [DEPTH];
    logic                  w_valid [DEPTH];
    logic                  w_flag  [DEPTH];
    logic                  w_cmp   [DEPTH];
    logic                  w_accept;
    logic                  w_pop;

    assign full      = (r_count == FULL_CNT);
    assign in_ready  = (r_state == ST_FILL) && !full;
    assign out_valid = (r_state == ST_DRAIN);
    assign out_data  = out_valid ? w_data[0] : '0;
    assign count     = r_count;
    assign dbg_state = r_state;
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [DATA_WIDTH-1:0] w_up_data;
            logic                  w_up_valid;
            logic                  w_up_flag;
            logic [DATA_WIDTH-1:0] w_dn_data;
            logic                  w_dn_valid;

`ifdef SORT_ARRAY_DESCEND_EN
            assign w_cmp[gi] = w_valid[gi] && (w_data[gi] < in_data);
`else
            assign w_cmp[gi] = w_valid[gi] && (w_data[gi] > in_data);
`endif

            if (gi == 0) begin : g_head
                assign w_up_data  = '0;
                assign w_up_valid = 1'b0;
                assign w_up_flag  = 1'b0;
            end else begin : g_body
                assign w_up_data  = w_data[gi-1];
                assign w_up_valid = w_valid[gi-1];
                assign w_up_flag  = w_flag[gi-1];
            end

            if (gi == DEPTH - 1) begin : g_tail
                assign w_dn_data  = '0;
                assign w_dn_valid = 1'b0;
            end else begin : g_mid
                assign w_dn_data  = w_data[gi+1];
                assign w_dn_valid = w_valid[gi+1];
            end

            sort_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
                .clk         (clk),
                .rst         (rst),
                .i_new       (in_data),
                .i_up_data   (w_up_data),
                .i_up_valid  (w_up_valid),
                .i_up_flag   (w_up_flag),
                .i_dn_data   (w_dn_data),
                .i_dn_valid  (w_dn_valid),
                .i_shift_in  (w_accept),
                .i_shift_out (w_pop),
                .i_cmp       (w_cmp[gi]),
                .o_data      (w_data[gi]),
                .o_valid     (w_valid[gi]),
                .o_flag      (w_flag[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
            r_count <= '0;
        end else begin
            if (r_state == ST_FILL) begin
                // A same-cycle accept makes an empty-array drain meaningful.
                if (drain && (r_count != '0 || w_accept)) begin
                    r_state <= ST_DRAIN;
                end
                if (w_accept) begin
                    r_count <= r_count + ONE_CNT;
                end
            end else if (w_pop) begin
                r_count <= r_count - ONE_CNT;
                if (r_count == ONE_CNT) begin
                    r_state <= ST_FILL;
                end
            end
        end
    end

endmodule

// File: tb/tb_sort_array.sv
// Directed bench for sort_array: scoreboard queue filled with hand-computed
// drain order, popped by a monitor whenever an output transfer occurs.
module tb_sort_array;

    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          drain;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          full;
    logic          dbg_state;

    logic [DW-1:0] exp_q[$];
    int n_checks;
    int n_errors;

    sort_array #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .drain     (drain),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // driver tasks
    task automatic insert(input logic [DW-1:0] v);
        in_data  = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_drain();
        drain = 1'b1;
        @(posedge clk); #1;
        drain = 1'b0;
    endtask

    task automatic wait_drain_done(input string name);
        int cyc;
        cyc = 0;
        while (out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_done"}, int'(out_valid), 0);
        check({name, "_q_empty"}, exp_q.size(), 0);
        check({name, "_count0"}, int'(count), 0);
        check({name, "_in_ready"}, int'(in_ready), 1);
        exp_q.delete();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        drain     = 1'b0;
        out_ready = 1'b1;

        // monitor / scoreboard
        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_pop: got %0d expected none", out_data);
                    end else begin
                        check("drain_data", int'(out_data), int'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        do_reset();
        check("rst_count", int'(count), 0);
        check("rst_full", int'(full), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_state", int'(dbg_state), 0);

`ifdef SORT_ARRAY_DESCEND_EN
        insert(8'd5); insert(8'd2); insert(8'd9);
        check("desc_count", int'(count), 3);
        exp_q.push_back(8'd9); exp_q.push_back(8'd5); exp_q.push_back(8'd2);
        pulse_drain();
        check("desc_ov", int'(out_valid), 1);
        wait_drain_done("desc");
`else
        // basic fill with a tie
        insert(8'd5); insert(8'd2); insert(8'd9); insert(8'd2);
        check("t1_count", int'(count), 4);
        check("t1_ov_fill", int'(out_valid), 0);
        exp_q.push_back(8'd2); exp_q.push_back(8'd2);
        exp_q.push_back(8'd5); exp_q.push_back(8'd9);
        pulse_drain();
        check("t1_ov", int'(out_valid), 1);
        check("t1_in_ready_drain", int'(in_ready), 0);
        wait_drain_done("t1");
        check("t1_state", int'(dbg_state), 0);

        // full boundary with in_valid held high
        in_valid = 1'b1;
        for (int v = 8; v >= 1; v--) begin
            in_data = DW'(v);
            @(posedge clk); #1;
        end
        check("t2_full", int'(full), 1);
        check("t2_in_ready", int'(in_ready), 0);
        in_data = 8'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t2_count", int'(count), 8);
        for (int v = 1; v <= 8; v++) exp_q.push_back(DW'(v));
        pulse_drain();
        wait_drain_done("t2");

        // accept together with drain
        insert(8'd7); insert(8'd1); insert(8'd4);
        check("t3_count", int'(count), 3);
        exp_q.push_back(8'd1); exp_q.push_back(8'd3);
        exp_q.push_back(8'd4); exp_q.push_back(8'd7);
        in_data  = 8'd3;
        in_valid = 1'b1;
        drain    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain    = 1'b0;
        check("t3_ov", int'(out_valid), 1);
        wait_drain_done("t3");

        // backpressure
        insert(8'd6); insert(8'd2); insert(8'd4);
        out_ready = 1'b0;
        pulse_drain();
        for (int c = 0; c < 3; c++) begin
            check("t4_ov", int'(out_valid), 1);
            check("t4_hold_data", int'(out_data), 2);
            check("t4_hold_count", int'(count), 3);
            @(posedge clk); #1;
        end
        exp_q.push_back(8'd2); exp_q.push_back(8'd4); exp_q.push_back(8'd6);
        out_ready = 1'b1;
        wait_drain_done("t4");

        // empty drain is ignored
        pulse_drain();
        check("t5_state", int'(dbg_state), 0);
        check("t5_ov", int'(out_valid), 0);
        check("t5_in_ready", int'(in_ready), 1);

        // reset after two of five pops
        insert(8'd50); insert(8'd10); insert(8'd40); insert(8'd20); insert(8'd30);
        exp_q.push_back(8'd10); exp_q.push_back(8'd20);
        pulse_drain();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t6_count_mid", int'(count), 3);
        rst       = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        check("t6_count", int'(count), 0);
        check("t6_ov", int'(out_valid), 0);
        check("t6_in_ready", int'(in_ready), 1);
        check("t6_q_empty", exp_q.size(), 0);
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
